// File: rtl/bp_be_dcache_fill_engine.sv
// bp_be_dcache_fill_engine
// Responder for the back-end D$ miss interface. A cache miss is refilled one
// dword beat at a time over the memory port, then written back into the D$
// as a data packet, a tag packet and a stat packet. Uncached loads return one
// dword through the data packet. Uncached stores issue a single memory write.
// One request is serviced at a time, with at most one memory command in flight.
//
// state | meaning
// IDLE  | ready; accepts the next cache request
// META  | miss waits for the victim way from the cache
// CMD   | memory command valid (one beat, or the single uncached access)
// RESP  | waits for the memory response and stores it in the block buffer
// DATA  | data packet valid (full block, or uncached load dword in slot 0)
// TAG   | tag packet valid (misses only)
// STAT  | stat packet valid: LRU to the filled way, dirty cleared (misses only)
// DONE  | one-cycle completion pulse back to the cache
module bp_be_dcache_fill_engine #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int block_width_p = 512,
    parameter int sets_p        = 64,
    parameter int assoc_p       = 8,
    parameter int ptag_width_p  = 28
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic                          cache_req_v_i,
    output logic                          cache_req_ready_o,
    input  logic [1:0]                    cache_req_type_i,
    input  logic [paddr_width_p-1:0]      cache_req_addr_i,
    input  logic [dword_width_p-1:0]      cache_req_data_i,
    input  logic                          cache_req_metadata_v_i,
    input  logic [$clog2(assoc_p)-1:0]    cache_req_way_i,
    output logic                          cache_req_complete_o,

    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_ready_i,
    output logic                          mem_cmd_wr_o,
    output logic [paddr_width_p-1:0]      mem_cmd_addr_o,
    output logic [dword_width_p-1:0]      mem_cmd_data_o,

    input  logic                          mem_resp_v_i,
    input  logic [dword_width_p-1:0]      mem_resp_data_i,
    output logic                          mem_resp_yumi_o,

    output logic                          data_mem_pkt_v_o,
    input  logic                          data_mem_pkt_ready_i,
    output logic [$clog2(sets_p)-1:0]     data_mem_index_o,
    output logic [$clog2(assoc_p)-1:0]    data_mem_way_o,
    output logic                          data_mem_uncached_o,
    output logic [block_width_p-1:0]      data_mem_data_o,

    output logic                          tag_mem_pkt_v_o,
    input  logic                          tag_mem_pkt_ready_i,
    output logic [$clog2(sets_p)-1:0]     tag_mem_index_o,
    output logic [$clog2(assoc_p)-1:0]    tag_mem_way_o,
    output logic [ptag_width_p-1:0]       tag_mem_tag_o,

    output logic                          stat_mem_pkt_v_o,
    input  logic                          stat_mem_pkt_ready_i,
    output logic [$clog2(sets_p)-1:0]     stat_mem_index_o,
    output logic [$clog2(assoc_p)-1:0]    stat_mem_way_o
);

    localparam int beats_lp        = block_width_p / dword_width_p;
    localparam int beat_w_lp       = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int index_w_lp      = $clog2(sets_p);
    localparam int way_w_lp        = $clog2(assoc_p);
    localparam int block_offset_lp = $clog2(block_width_p / 8);
    localparam int dword_offset_lp = $clog2(dword_width_p / 8);

    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_lp - 1);

    // Request type encoding: bit 1 = uncached, bit 0 = store.
    typedef enum logic [1:0] {
        e_req_load_miss  = 2'd0,
        e_req_store_miss = 2'd1,
        e_req_uc_load    = 2'd2,
        e_req_uc_store   = 2'd3
    } req_type_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_META = 3'd1,
        S_CMD  = 3'd2,
        S_RESP = 3'd3,
        S_DATA = 3'd4,
        S_TAG  = 3'd5,
        S_STAT = 3'd6,
        S_DONE = 3'd7
    } state_e;

    state_e                     r_state;
    state_e                     w_state_n;

    req_type_e                  r_type;
    logic [paddr_width_p-1:0]   r_addr;
    logic [dword_width_p-1:0]   r_data;
    logic [way_w_lp-1:0]        r_way;
    logic                       r_meta_seen;
    logic [beat_w_lp-1:0]       r_beat;
    logic [block_width_p-1:0]   r_block;

    logic                       w_accept;
    logic                       w_is_uncached;
    logic                       w_is_store;
    logic                       w_resp_fire;
    logic [paddr_width_p-1:0]   w_beat_addr;

    assign w_accept      = (r_state == S_IDLE) && cache_req_v_i;
    assign w_is_uncached = r_type[1];
    assign w_is_store    = r_type[0];
    assign w_resp_fire   = (r_state == S_RESP) && mem_resp_v_i;

    // Miss beats walk the block from its aligned base, one dword per beat.
    assign w_beat_addr = {r_addr[paddr_width_p-1:block_offset_lp], r_beat, {dword_offset_lp{1'b0}}};

    // Payloads come straight from registers, so they cannot move while a valid is held.
    assign mem_cmd_wr_o        = w_is_uncached && w_is_store;
    assign mem_cmd_addr_o      = w_is_uncached ? r_addr : w_beat_addr;
    assign mem_cmd_data_o      = r_data;

    assign data_mem_index_o    = r_addr[block_offset_lp +: index_w_lp];
    assign data_mem_way_o      = w_is_uncached ? '0 : r_way;
    assign data_mem_uncached_o = w_is_uncached;
    assign data_mem_data_o     = r_block;

    assign tag_mem_index_o     = r_addr[block_offset_lp +: index_w_lp];
    assign tag_mem_way_o       = r_way;
    assign tag_mem_tag_o       = r_addr[paddr_width_p-1 -: ptag_width_p];

    assign stat_mem_index_o    = r_addr[block_offset_lp +: index_w_lp];
    assign stat_mem_way_o      = r_way;

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Request capture, victim way capture, beat counter and refill buffer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_type      <= e_req_load_miss;
            r_addr      <= '0;
            r_data      <= '0;
            r_way       <= '0;
            r_meta_seen <= 1'b0;
            r_beat      <= '0;
            r_block     <= '0;
        end else begin
            if (w_accept) begin
                r_type      <= req_type_e'(cache_req_type_i);
                r_addr      <= cache_req_addr_i;
                r_data      <= cache_req_data_i;
                r_beat      <= '0;
                r_meta_seen <= cache_req_metadata_v_i;
                if (cache_req_metadata_v_i) begin
                    r_way <= cache_req_way_i;
                end
            end

            if ((r_state == S_META) && cache_req_metadata_v_i) begin
                r_way       <= cache_req_way_i;
                r_meta_seen <= 1'b1;
            end

            if (w_resp_fire) begin
                if (!w_is_uncached) begin
                    r_block[r_beat*dword_width_p +: dword_width_p] <= mem_resp_data_i;
                    r_beat <= r_beat + beat_w_lp'(1);
                end else if (!w_is_store) begin
                    r_block[0 +: dword_width_p] <= mem_resp_data_i;
                end
            end
        end
    end

    // Next state and Moore handshake outputs.
    always_comb begin
        w_state_n            = r_state;
        cache_req_ready_o    = 1'b0;
        cache_req_complete_o = 1'b0;
        mem_cmd_v_o          = 1'b0;
        mem_resp_yumi_o      = 1'b0;
        data_mem_pkt_v_o     = 1'b0;
        tag_mem_pkt_v_o      = 1'b0;
        stat_mem_pkt_v_o     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                cache_req_ready_o = 1'b1;
                if (cache_req_v_i) begin
                    w_state_n = cache_req_type_i[1] ? S_CMD : S_META;
                end
            end

            S_META: begin
                if (r_meta_seen || cache_req_metadata_v_i) begin
                    w_state_n = S_CMD;
                end
            end

            S_CMD: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) begin
                    w_state_n = S_RESP;
                end
            end

            S_RESP: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    if (!w_is_uncached) begin
                        w_state_n = (r_beat == last_beat_lp) ? S_DATA : S_CMD;
                    end else if (w_is_store) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_state_n = S_DATA;
                    end
                end
            end

            S_DATA: begin
                data_mem_pkt_v_o = 1'b1;
                if (data_mem_pkt_ready_i) begin
                    w_state_n = w_is_uncached ? S_DONE : S_TAG;
                end
            end

            S_TAG: begin
                tag_mem_pkt_v_o = 1'b1;
                if (tag_mem_pkt_ready_i) begin
                    w_state_n = S_STAT;
                end
            end

            S_STAT: begin
                stat_mem_pkt_v_o = 1'b1;
                if (stat_mem_pkt_ready_i) begin
                    w_state_n = S_DONE;
                end
            end

            S_DONE: begin
                cache_req_complete_o = 1'b1;
                w_state_n            = S_IDLE;
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/bp_be_dcache_fill_engine.md
# bp_be_dcache_fill_engine

Responder end of the back-end D$ miss interface: accepts cache requests and metadata issued by the BE data cache and services them against a dword-wide memory port. It then writes the refill back into the D$ through the data, tag and stat memory packet ports and signals `cache_req_complete`. It sits between `bp_be_mem_top` (cache side) and the memory or uncore (memory side) in single-core, write-through D$ configurations. It has no coherence and no victim writeback.

## Interface
Parameters:
- `paddr_width_p`, 40: physical address width.
- `dword_width_p`, 64: memory beat width.
- `block_width_p`, 512: D$ block width; beats per block N = `block_width_p`/`dword_width_p`.
- `sets_p`, 64: D$ sets.
- `assoc_p`, 8: D$ ways.
- `ptag_width_p`, 28: physical tag width.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `cache_req_v_i` / `cache_req_ready_o`  in/out  1  request valid-ready handshake.
- `cache_req_type_i`  in  2  request type: 0 load miss, 1 store miss, 2 uncached load, 3 uncached store.
- `cache_req_addr_i`  in  `paddr_width_p`  request address.
- `cache_req_data_i`  in  `dword_width_p`  uncached store data.
- `cache_req_metadata_v_i`  in  1  victim way valid.
- `cache_req_way_i`  in  lg(`assoc_p`)  victim way.
- `cache_req_complete_o`  out  1  one-cycle pulse when a request is finished.
- `mem_cmd_v_o` / `mem_cmd_ready_i`  out/in  1  memory command handshake.
- `mem_cmd_wr_o`  out  1  command is a write.
- `mem_cmd_addr_o`  out  `paddr_width_p`  command address.
- `mem_cmd_data_o`  out  `dword_width_p`  write data.
- `mem_resp_v_i`  in  1  memory response valid.
- `mem_resp_data_i`  in  `dword_width_p`  read response data.
- `mem_resp_yumi_o`  out  1  response consumed.
- `data_mem_pkt_v_o` / `data_mem_pkt_ready_i`  out/in  1  data packet handshake.
- `data_mem_index_o`  out  lg(`sets_p`)  data packet set index.
- `data_mem_way_o`  out  lg(`assoc_p`)  data packet way.
- `data_mem_uncached_o`  out  1  data packet carries uncached load data.
- `data_mem_data_o`  out  `block_width_p`  data packet payload.
- `tag_mem_pkt_v_o` / `tag_mem_pkt_ready_i`  out/in  1  tag packet handshake.
- `tag_mem_index_o`, `tag_mem_way_o`, `tag_mem_tag_o`  out  as above / `ptag_width_p`  tag packet fields.
- `stat_mem_pkt_v_o` / `stat_mem_pkt_ready_i`  out/in  1  stat packet handshake.
- `stat_mem_index_o`, `stat_mem_way_o`  out  as above  stat packet fields; the write sets LRU to the way and clears dirty.

## Operation
- States: IDLE, META, CMD, RESP, DATA, TAG, STAT, DONE.
- IDLE:
  - `cache_req_ready_o`=1.
  - On `cache_req_v_i`: register type, addr, data; clear beat counter.
  - Misses go to META. Uncached requests go to CMD.
- META:
  - Wait for `cache_req_metadata_v_i` and register the way. Metadata asserted in the accept cycle is also captured, but META still lasts at least 1 cycle.
  - Exit to CMD.
- CMD:
  - `mem_cmd_v_o`=1.
  - Misses: read, addr = block-aligned addr + beat×8.
  - Uncached: addr = request addr; `mem_cmd_wr_o`=1 for stores, with data = stored data.
  - On handshake go to RESP.
- RESP:
  - `mem_resp_yumi_o`=`mem_resp_v_i`.
  - Misses: place the data into block slot [beat]. If beat==N-1 go to DATA, else beat++ and go to CMD.
  - Uncached load: place the data in slot 0 and go to DATA.
  - Uncached store: go to DONE (response data ignored).
- DATA:
  - Packet: index = addr[6 +: lg(`sets_p`)], way = registered way, uncached flag = request type.
  - On handshake: miss goes to TAG, uncached goes to DONE.
- TAG:
  - Packet: tag = addr[`paddr_width_p`-1 -: `ptag_width_p`].
  - On handshake go to STAT.
- STAT: on handshake go to DONE.
- DONE: `cache_req_complete_o`=1 for exactly one cycle, then go to IDLE.
- Uncached data packets: way = 0; only the low dword of the payload is meaningful.
- Only one request is outstanding at a time.
- At most one memory command is in flight; the next command is issued only after its response.

## Timing
- Reset (async assert, applied in any state):
  - state=IDLE, beat counter=0, block buffer=0.
  - All `*_v_o`, `mem_resp_yumi_o` and `cache_req_complete_o` are 0.
  - `cache_req_ready_o`=1, because it is decoded from state.
- Reset mid-request: the request is dropped with no complete pulse. The memory side shares the reset.
- All valid outputs are Moore, decoded from registered state. They hold until the handshake; their payloads are stable while valid.
- A memory response is consumed at the earliest one cycle after its command handshake.
- Zero-wait latency, measured from the accept cycle (cycle 0) to the `complete` pulse:
  - load or store miss: cycle 21;
  - uncached load: cycle 4;
  - uncached store: cycle 3.
- Ready stalls on any port add cycles one-for-one. The state does not advance while valid is asserted and ready is low.
- Beat counter: lg(N) bits, only wraps after beat N-1, and is reset on accept.
- `cache_req_v_i` outside IDLE is ignored; it is not accepted.

## Test plan
- Load miss:
  - Stimulus: addr=0x80001048, metadata way=5 in the accept cycle, memory returns dword k = 0x1111_0000+k.
  - Response: 8 reads at 0x80001040..0x80001078; data packet index 0x01, way 5, slot k = 0x1111_0000+k; tag 0x0080001; stat index 1 way 5; complete at cycle 21.
- Store miss with late metadata:
  - Stimulus: metadata arrives at cycle 4.
  - Response: first command at cycle 5; complete at cycle 24.
- Uncached load:
  - Stimulus: addr 0x10000000, response 0xDEADBEEF.
  - Response: a single read; data packet with uncached=1, low dword 0xDEADBEEF; no tag or stat packet; complete at cycle 4.
- Uncached store:
  - Stimulus: data 0xA5A5.
  - Response: one write carrying that data; no cache packets; complete at cycle 3.
- Backpressure:
  - Stimulus: `mem_cmd_ready_i` and `tag_mem_pkt_ready_i` held low 3 cycles each.
  - Response: valids held with stable payload; complete delayed by 6 cycles.
- Reset asserted during RESP beat 3:
  - Response: all outputs at reset values immediately; no complete pulse; next request serviced normally.
